// File: rtl/birrd_cmd_sequencer.sv
// Command sequencer for the BIRRD network: steps a command table one beat
// per accepted input and tracks beats through the fixed network latency.
module birrd_cmd_sequencer #(
    parameter int NUM_INPUT_DATA   = 16,
    parameter int IN_COMMAND_WIDTH = 14,
    parameter int NUM_CFG          = 8,
    parameter int LATENCY          = 2 * $clog2(NUM_INPUT_DATA) - 1,
    localparam int TOTAL_COMMAND   = (NUM_INPUT_DATA / 2) * IN_COMMAND_WIDTH,
    localparam int AW              = $clog2(NUM_CFG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_wr_en,
    input  logic [AW-1:0]            cfg_wr_addr,
    input  logic [TOTAL_COMMAND-1:0] cfg_wr_data,
    input  logic                     start,
    input  logic [AW-1:0]            start_idx,
    input  logic [7:0]               num_steps,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     net_en,
    output logic [TOTAL_COMMAND-1:0] net_cmd,
    output logic                     net_fire,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                   state;
    logic [AW-1:0]            cur_idx;
    logic [7:0]               steps_left;
    logic [CW-1:0]            drain_cnt;
    logic [LATENCY-1:0]       pipe;
    logic [LATENCY-1:0]       pipe_d;
    logic [TOTAL_COMMAND-1:0] cmd_mem [NUM_CFG];
    logic [TOTAL_COMMAND-1:0] snap;
    logic                     snap_vld;

    assign busy     = (state != IDLE);
    assign net_en   = busy;
    assign in_ready = (state == RUN);
    assign net_fire = in_valid && in_ready;
    assign out_valid = pipe[LATENCY-1];

    // The start-cycle snapshot keeps the first beat on the pre-write entry
    // when the table is rewritten in the same cycle as start.
    assign net_cmd = !net_fire ? '0 :
                     snap_vld  ? snap : cmd_mem[cur_idx];

    if (LATENCY == 1) begin : g_pipe1
        assign pipe_d = net_fire;
    end else begin : g_pipen
        assign pipe_d = {pipe[LATENCY-2:0], net_fire};
    end

    always_ff @(posedge clk) begin
        if (cfg_wr_en) cmd_mem[cfg_wr_addr] <= cfg_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_idx    <= '0;
            steps_left <= '0;
            drain_cnt  <= '0;
            pipe       <= '0;
            done       <= 1'b0;
            snap       <= '0;
            snap_vld   <= 1'b0;
        end else begin
            pipe <= pipe_d;
            done <= 1'b0;
            if (net_fire || (cfg_wr_en && cfg_wr_addr == cur_idx))
                snap_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_steps != 8'd0) begin
                            state      <= RUN;
                            cur_idx    <= start_idx;
                            steps_left <= num_steps;
                            snap       <= cmd_mem[start_idx];
                            snap_vld   <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (net_fire) begin
                        cur_idx    <= cur_idx + 1'b1;
                        steps_left <= steps_left - 8'd1;
                        if (steps_left == 8'd1) begin
                            state     <= DRAIN;
                            drain_cnt <= CW'(LATENCY - 1);
                            done      <= (LATENCY == 1);
                        end
                    end
                end
                DRAIN: begin
                    // done lands on the final beat's out_valid; IDLE follows.
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        if (drain_cnt == CW'(1)) done <= 1'b1;
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_birrd_cmd_sequencer.sv
// Directed testbench for birrd_cmd_sequencer with default parameters
// (16 ports, 8-entry table, latency 7).
module tb_birrd_cmd_sequencer;

    localparam int L  = 7;
    localparam int TC = 112;
    localparam int AW = 3;
    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [TC-1:0] cfg_wr_data;
    logic          start;
    logic [AW-1:0] start_idx;
    logic [7:0]    num_steps;
    logic          in_valid;
    logic          in_ready;
    logic          net_en;
    logic [TC-1:0] net_cmd;
    logic          net_fire;
    logic          out_valid;
    logic          busy;
    logic          done;

    birrd_cmd_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .start       (start),
        .start_idx   (start_idx),
        .num_steps   (num_steps),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .net_en      (net_en),
        .net_cmd     (net_cmd),
        .net_fire    (net_fire),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic [TC-1:0] model [NC];
    int            fire_q [$];
    logic [TC-1:0] cmd_q [$];
    int            ov_q [$];
    int            done_q [$];
    int            last_busy;
    bit            busy_seen;

    function automatic logic [TC-1:0] pat(input int k);
        logic [27:0] w;
        w = 28'(32'h0A5C_0000 + k);
        pat = {4{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [TC-1:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(a);
        cfg_wr_data = d;
        step();
        cfg_wr_en = 1'b0;
        model[a]  = d;
    endtask

    task automatic sample(input int k);
        if (net_fire) begin
            fire_q.push_back(k);
            cmd_q.push_back(net_cmd);
        end
        if (out_valid) ov_q.push_back(k);
        if (done) done_q.push_back(k);
        if (busy) begin
            busy_seen = 1'b1;
            last_busy = k;
        end
    endtask

    // Cycle 0 is the first cycle after the start edge; the start cycle is -1.
    task automatic run_seq(input int idx, input int n, input logic [63:0] vpat,
                           input int restart_at, input bit wr, input int waddr,
                           input logic [TC-1:0] wdata);
        fire_q.delete();
        cmd_q.delete();
        ov_q.delete();
        done_q.delete();
        last_busy = -2;
        busy_seen = 1'b0;
        start       = 1'b1;
        start_idx   = AW'(idx);
        num_steps   = 8'(n);
        in_valid    = 1'b0;
        cfg_wr_en   = wr;
        cfg_wr_addr = AW'(waddr);
        cfg_wr_data = wdata;
        @(negedge clk);
        sample(-1);
        step();
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        for (int k = 0; k < 30; k++) begin
            in_valid = vpat[k];
            if (k == restart_at) begin
                start     = 1'b1;
                start_idx = '0;
                num_steps = 8'd8;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            sample(k);
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        num_steps = 8'd4;
        #3;
        total_cnt++;
        if ({in_ready, net_en, net_fire, out_valid, busy, done} !== 6'b0) begin
            $display("FAIL reset_ctl: got %b want 000000",
                     {in_ready, net_en, net_fire, out_valid, busy, done});
        end else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (net_cmd !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_held: cmd=%h busy=%b done=%b want 0",
                     net_cmd, busy, done);
        end else pass_cnt++;
        start = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        run_seq(0, 4, {64{1'b1}}, -1, 1'b0, 0, '0);
        total_cnt++;
        if (fire_q.size() != 4) $display("FAIL basic_nfire: got %0d want 4", fire_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (i >= fire_q.size() || fire_q[i] != i || cmd_q[i] !== model[i])
                $display("FAIL basic_beat%0d: got cyc %0d cmd %h want cyc %0d cmd %h", i,
                         (i < fire_q.size()) ? fire_q[i] : -1,
                         (i < cmd_q.size()) ? cmd_q[i] : '0, i, model[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (ov_q.size() != 4 || ov_q[0] != L || ov_q[3] != L + 3)
            $display("FAIL basic_ov: got n=%0d first=%0d want n=4 first=%0d",
                     ov_q.size(), (ov_q.size() > 0) ? ov_q[0] : -1, L);
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != L + 3)
            $display("FAIL basic_done: got n=%0d at %0d want 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, L + 3);
        else pass_cnt++;
        total_cnt++;
        if (last_busy != L + 3)
            $display("FAIL basic_busy_end: got %0d want %0d", last_busy, L + 3);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int exp_i [4];
        exp_i = '{6, 7, 0, 1};
        run_seq(6, 4, {64{1'b1}}, -1, 1'b0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (i >= cmd_q.size() || cmd_q[i] !== model[exp_i[i]])
                $display("FAIL wrap_cmd%0d: got %h want %h", i,
                         (i < cmd_q.size()) ? cmd_q[i] : '0, model[exp_i[i]]);
            else pass_cnt++;
        end
    endtask

    task automatic test_bubble();
        int exp_f [3];
        exp_f = '{0, 3, 4};
        run_seq(1, 3, 64'b11001, -1, 1'b0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (i >= fire_q.size() || fire_q[i] != exp_f[i] || cmd_q[i] !== model[1 + i])
                $display("FAIL bubble_fire%0d: got cyc %0d want cyc %0d", i,
                         (i < fire_q.size()) ? fire_q[i] : -1, exp_f[i]);
            else pass_cnt++;
            total_cnt++;
            if (i >= ov_q.size() || ov_q[i] != exp_f[i] + L)
                $display("FAIL bubble_ov%0d: got %0d want %0d", i,
                         (i < ov_q.size()) ? ov_q[i] : -1, exp_f[i] + L);
            else pass_cnt++;
        end
        total_cnt++;
        if (fire_q.size() != 3 || ov_q.size() != 3)
            $display("FAIL bubble_count: got fires %0d ov %0d want 3 3",
                     fire_q.size(), ov_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 4 + L)
            $display("FAIL bubble_done: got n=%0d at %0d want 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, 4 + L);
        else pass_cnt++;
    endtask

    task automatic test_zero_steps();
        run_seq(3, 0, {64{1'b1}}, -1, 1'b0, 0, '0);
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 0)
            $display("FAIL zero_done: got n=%0d at %0d want 1 at 0",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (busy_seen || fire_q.size() != 0)
            $display("FAIL zero_quiet: got busy %0d fires %0d want 0 0",
                     busy_seen, fire_q.size());
        else pass_cnt++;
    endtask

    task automatic test_restart_in_drain();
        run_seq(0, 2, {64{1'b1}}, 3, 1'b0, 0, '0);
        total_cnt++;
        if (fire_q.size() != 2)
            $display("FAIL drain_restart_fires: got %0d want 2", fire_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 1 + L || last_busy != 1 + L)
            $display("FAIL drain_restart_done: got n=%0d busy_end %0d want 1 %0d",
                     done_q.size(), last_busy, 1 + L);
        else pass_cnt++;
    endtask

    task automatic test_write_on_start();
        logic [TC-1:0] old2;
        old2 = model[2];
        run_seq(2, 2, {64{1'b1}}, -1, 1'b1, 2, pat(99));
        model[2] = pat(99);
        total_cnt++;
        if (cmd_q.size() != 2 || cmd_q[0] !== old2 || cmd_q[1] !== model[3])
            $display("FAIL wr_start_old: got %h want %h",
                     (cmd_q.size() > 0) ? cmd_q[0] : '0, old2);
        else pass_cnt++;
        run_seq(2, 1, {64{1'b1}}, -1, 1'b0, 0, '0);
        total_cnt++;
        if (cmd_q.size() != 1 || cmd_q[0] !== pat(99))
            $display("FAIL wr_start_new: got %h want %h",
                     (cmd_q.size() > 0) ? cmd_q[0] : '0, pat(99));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int n_done;
        int n_ov;
        n_done = 0;
        n_ov = 0;
        start     = 1'b1;
        start_idx = '0;
        num_steps = 8'd8;
        in_valid  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        total_cnt++;
        if (busy !== 1'b1 || net_fire !== 1'b1)
            $display("FAIL midrun_active: got busy %b fire %b want 1 1", busy, net_fire);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, net_en, net_fire, out_valid, busy, done} !== 6'b0 || net_cmd !== '0)
            $display("FAIL midrun_reset: got %b cmd %h want 000000 0",
                     {in_ready, net_en, net_fire, out_valid, busy, done}, net_cmd);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < L + 5; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (out_valid) n_ov++;
            step();
        end
        total_cnt++;
        if (n_done != 0 || n_ov != 0)
            $display("FAIL midrun_abandon: got done %0d ov %0d want 0 0", n_done, n_ov);
        else pass_cnt++;
        run_seq(4, 2, {64{1'b1}}, -1, 1'b0, 0, '0);
        total_cnt++;
        if (cmd_q.size() != 2 || cmd_q[0] !== model[4] || cmd_q[1] !== model[5])
            $display("FAIL midrun_table: got %h want %h",
                     (cmd_q.size() > 0) ? cmd_q[0] : '0, model[4]);
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 1 + L)
            $display("FAIL midrun_after_done: got n=%0d want 1 at %0d", done_q.size(), 1 + L);
        else pass_cnt++;
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_wr_en   = 1'b0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        start       = 1'b0;
        start_idx   = '0;
        num_steps   = '0;
        in_valid    = 1'b0;
        test_reset();
        for (int i = 0; i < NC; i++) write_entry(i, pat(16 + i));
        step();
        test_basic();
        test_wrap();
        test_bubble();
        test_zero_steps();
        test_restart_in_drain();
        test_write_on_start();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
